// File: rtl/lbm_field_stream_packer.sv
// Packs N solver lanes per cell into one 4*DATA_WIDTH AXI4-Stream beat per lane, TLAST on the last cell of a frame.
// Latency: a cell accepted at cycle t into an empty FIFO with the FSM idle shows tvalid at t+2; one beat per cycle sustained.
// Backpressure: DROP_MODE=0 drops s_ready when the FIFO is full; DROP_MODE=1 never stalls and drops instead, keeping one slot for the last cell.

module lbm_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
endmodule

module lbm_field_stream_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int N_CHANNELS = 2,
  parameter int DEPTH      = 2500,
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_MODE  = 0
)(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [N_CHANNELS*4*DATA_WIDTH-1:0] s_data,
  input  logic [7:0]                         decim,
  output logic                               m00_axis_tvalid,
  output logic [4*DATA_WIDTH-1:0]            m00_axis_tdata,
  output logic [4*DATA_WIDTH/8-1:0]          m00_axis_tstrb,
  output logic                               m00_axis_tlast,
  input  logic                               m00_axis_tready,
  output logic [15:0]                        frame_count,
  output logic                               overflow,
  output logic [15:0]                        drop_count
);
  localparam int TW    = 4 * DATA_WIDTH;
  localparam int SW    = N_CHANNELS * TW;
  localparam int EW    = SW + 1;
  localparam int CELLW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANEW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CELLW-1:0] LAST_CELL = CELLW'(DEPTH - 1);
  localparam logic [LANEW-1:0] LAST_LANE = LANEW'(N_CHANNELS - 1);
  localparam logic [CW-1:0]    FIFO_RSV  = CW'(FIFO_DEPTH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic                 run;
  logic [CELLW-1:0]     cell_cnt;
  logic [7:0]           decim_lat;
  logic [7:0]           decim_in;
  logic [7:0]           decim_eff;
  logic [7:0]           phase;
  logic [8:0]           phase_inc;
  logic                 last_cell;
  logic                 accept;
  logic                 keep;
  logic                 drop;
  logic                 push;
  logic                 pop;

  logic [EW-1:0]        fifo_head;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;

  state_t                           state;
  state_t                           state_nxt;
  logic [LANEW-1:0]                 lane;
  logic [LANEW-1:0]                 lane_nxt;
  logic [N_CHANNELS-1:0][TW-1:0]    hold_dat;
  logic                             hold_last;

  // ---------------- input side ----------------
  assign decim_in  = (decim == 8'd0) ? 8'd1 : decim;
  // At cell 0 the latch has not been written yet, so the live value governs this frame.
  assign decim_eff = (cell_cnt == '0) ? decim_in : decim_lat;
  assign last_cell = (cell_cnt == LAST_CELL);
  assign s_ready   = run && ((DROP_MODE != 0) || !fifo_full);
  assign accept    = s_valid && s_ready;
  assign keep      = (phase == 8'd0);
  assign phase_inc = {1'b0, phase} + 9'd1;

  always_comb begin
    drop = 1'b0;
    if ((DROP_MODE != 0) && accept && keep)
      drop = last_cell ? fifo_full : (fifo_count >= FIFO_RSV);
  end

  assign push = accept && keep && !drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run         <= 1'b0;
      cell_cnt    <= '0;
      frame_count <= 16'd0;
      decim_lat   <= 8'd1;
      phase       <= 8'd0;
      overflow    <= 1'b0;
      drop_count  <= 16'd0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        if (cell_cnt == '0) decim_lat <= decim_in;
        if (last_cell) begin
          cell_cnt    <= '0;
          frame_count <= frame_count + 16'd1;
          phase       <= (phase_inc >= {1'b0, decim_eff}) ? 8'd0 : phase_inc[7:0];
        end else begin
          cell_cnt <= cell_cnt + 1'b1;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  lbm_sample_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({last_cell, s_data}),
    .pop      (pop),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ---------------- output side ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lane      <= '0;
      hold_dat  <= '0;
      hold_last <= 1'b0;
    end else begin
      state <= state_nxt;
      lane  <= lane_nxt;
      if (pop) begin
        hold_dat  <= fifo_head[SW-1:0];
        hold_last <= fifo_head[SW];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          lane_nxt  = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (m00_axis_tready) begin
          if (lane != LAST_LANE) begin
            lane_nxt = lane + 1'b1;
          end else if (!fifo_empty) begin
            // Refill on the final-lane handshake so frames stream without a bubble.
            pop      = 1'b1;
            lane_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m00_axis_tvalid = (state == SEND);
  assign m00_axis_tdata  = hold_dat[lane];
  assign m00_axis_tlast  = (state == SEND) && hold_last && (lane == LAST_LANE);
  assign m00_axis_tstrb  = '1;
endmodule

// File: tb/tb_lbm_field_stream_packer.sv
// Directed bench: dut a is backpressure mode (DEPTH=4, FIFO_DEPTH=4), dut b is drop mode (DEPTH=8, FIFO_DEPTH=4).
module tb_lbm_field_stream_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut a
  logic         a_s_valid = 1'b0;
  logic         a_s_ready;
  logic [127:0] a_s_data = '0;
  logic [7:0]   a_decim = 8'd1;
  logic         a_tvalid;
  logic [63:0]  a_tdata;
  logic [7:0]   a_tstrb;
  logic         a_tlast;
  logic         a_tready = 1'b1;
  logic [15:0]  a_frame_count;
  logic         a_overflow;
  logic [15:0]  a_drop_count;

  // dut b
  logic         b_s_valid = 1'b0;
  logic         b_s_ready;
  logic [127:0] b_s_data = '0;
  logic [7:0]   b_decim = 8'd1;
  logic         b_tvalid;
  logic [63:0]  b_tdata;
  logic [7:0]   b_tstrb;
  logic         b_tlast;
  logic         b_tready = 1'b0;
  logic [15:0]  b_frame_count;
  logic         b_overflow;
  logic [15:0]  b_drop_count;

  lbm_field_stream_packer #(
    .DATA_WIDTH(16), .N_CHANNELS(2), .DEPTH(4), .FIFO_DEPTH(4), .DROP_MODE(0)
  ) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .decim(a_decim), .m00_axis_tvalid(a_tvalid), .m00_axis_tdata(a_tdata),
    .m00_axis_tstrb(a_tstrb), .m00_axis_tlast(a_tlast), .m00_axis_tready(a_tready),
    .frame_count(a_frame_count), .overflow(a_overflow), .drop_count(a_drop_count)
  );

  lbm_field_stream_packer #(
    .DATA_WIDTH(16), .N_CHANNELS(2), .DEPTH(8), .FIFO_DEPTH(4), .DROP_MODE(1)
  ) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .decim(b_decim), .m00_axis_tvalid(b_tvalid), .m00_axis_tdata(b_tdata),
    .m00_axis_tstrb(b_tstrb), .m00_axis_tlast(b_tlast), .m00_axis_tready(b_tready),
    .frame_count(b_frame_count), .overflow(b_overflow), .drop_count(b_drop_count)
  );

  // Lane k of tag v: field f = f*0x1000 + k*0x100 + v, so lane0 u_x = v and lane1 u_x = 0x100+v.
  function automatic logic [63:0] lane_word(input int k, input logic [7:0] v);
    logic [15:0] base;
    base = 16'(k * 256) + {8'h00, v};
    return {base + 16'h3000, base + 16'h2000, base + 16'h1000, base};
  endfunction

  function automatic logic [127:0] cell_data(input logic [7:0] v);
    return {lane_word(1, v), lane_word(0, v)};
  endfunction

  // Beat monitors
  logic [63:0] a_qd[$];
  logic        a_ql[$];
  int          a_qc[$];
  int          a_first_vld = -1;
  logic [63:0] b_qd[$];
  logic        b_ql[$];

  always @(negedge clk) begin
    if (a_first_vld < 0 && a_tvalid) a_first_vld = cyc;
    if (a_tvalid && a_tready) begin
      a_qd.push_back(a_tdata);
      a_ql.push_back(a_tlast);
      a_qc.push_back(cyc);
    end
    if (b_tvalid && b_tready) begin
      b_qd.push_back(b_tdata);
      b_ql.push_back(b_tlast);
    end
  end

  task automatic clear_a();
    a_qd.delete(); a_ql.delete(); a_qc.delete(); a_first_vld = -1;
  endtask

  // Presents tag v on dut a until accepted; leaves s_valid high for the caller to drop.
  task automatic a_send(input logic [7:0] v, output int acc_cyc);
    logic ok;
    int   guard;
    ok = 1'b0; guard = 0; acc_cyc = -1;
    a_s_valid = 1'b1;
    a_s_data  = cell_data(v);
    while (!ok && guard < 300) begin
      @(negedge clk);
      ok = a_s_ready;
      acc_cyc = cyc;
      guard++;
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL a_send_timeout tag=%0h got s_ready=0 for 300 cycles, need 1", v);
    end
  endtask

  task automatic wait_a(input int n, input int limit);
    int i;
    i = 0;
    while (a_qd.size() < n && i < limit) begin @(posedge clk); i++; end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (a_tvalid !== 1'b0 || a_tlast !== 1'b0 || a_tdata !== 64'd0 || a_s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got tvalid=%b tlast=%b tdata=%h s_ready=%b, need 0 0 0 0",
               a_tvalid, a_tlast, a_tdata, a_s_ready);
    end
    n_tests++;
    if (a_frame_count !== 16'd0 || b_overflow !== 1'b0 || b_drop_count !== 16'd0 || a_tstrb !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_counters got frame=%0d ovf=%b drops=%0d tstrb=%h, need 0 0 0 ff",
               a_frame_count, b_overflow, b_drop_count, a_tstrb);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (a_s_ready !== 1'b1 || b_s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got a=%b b=%b, need 1 1", a_s_ready, b_s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int acc0, acc;
    clear_a();
    a_tready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      a_send(8'(c), acc);
      if (c == 0) acc0 = acc;
    end
    a_s_valid = 1'b0;
    wait_a(8, 60);
    n_tests++;
    if (a_qd.size() != 8) begin
      n_fail++; $display("FAIL basic_count got %0d beats, need 8", a_qd.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (a_qd[i] !== lane_word(i % 2, 8'(i / 2)) || a_ql[i] !== (i == 7)) begin
          n_fail++;
          $display("FAIL basic_beat%0d got %h last=%b, need %h last=%b",
                   i, a_qd[i], a_ql[i], lane_word(i % 2, 8'(i / 2)), (i == 7));
        end
      end
    end
    n_tests++;
    if (a_frame_count !== 16'd1) begin
      n_fail++; $display("FAIL basic_frame_count got %0d, need 1", a_frame_count);
    end
    n_tests++;
    if (a_first_vld - acc0 != 2) begin
      n_fail++; $display("FAIL basic_latency got %0d cycles, need 2", a_first_vld - acc0);
    end
  endtask

  task automatic test_decim();
    int acc, idx, nlast;
    clear_a();
    a_decim = 8'd3;
    for (int f = 0; f < 9; f++)
      for (int c = 0; c < 4; c++) a_send(8'(f * 4 + c), acc);
    a_s_valid = 1'b0;
    wait_a(24, 100);
    n_tests++;
    if (a_qd.size() != 24) begin
      n_fail++; $display("FAIL decim_count got %0d beats, need 24", a_qd.size());
    end else begin
      idx = 0; nlast = 0;
      for (int f = 0; f < 9; f += 3)
        for (int c = 0; c < 4; c++)
          for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (a_qd[idx] !== lane_word(k, 8'(f * 4 + c)) || a_ql[idx] !== (c == 3 && k == 1)) begin
              n_fail++;
              $display("FAIL decim_beat%0d got %h last=%b, need %h last=%b", idx, a_qd[idx],
                       a_ql[idx], lane_word(k, 8'(f * 4 + c)), (c == 3 && k == 1));
            end
            if (a_ql[idx]) nlast++;
            idx++;
          end
      n_tests++;
      if (nlast != 3) begin
        n_fail++; $display("FAIL decim_tlast_count got %0d, need 3", nlast);
      end
    end
    n_tests++;
    if (a_frame_count !== 16'd10 || a_drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL decim_counters got frame=%0d drops=%0d, need 10 0", a_frame_count, a_drop_count);
    end
    a_decim = 8'd1;
  endtask

  task automatic test_backpressure();
    int acc, tmp;
    clear_a();
    a_tready = 1'b0;
    acc = 0;
    repeat (20) begin
      a_s_valid = 1'b1;
      a_s_data  = cell_data(8'(acc));
      @(negedge clk);
      if (a_s_ready) acc++;
      @(posedge clk); #1;
    end
    a_s_valid = 1'b0;
    n_tests++;
    if (acc != 5) begin
      n_fail++; $display("FAIL bp_accepts got %0d, need 5", acc);
    end
    a_tready = 1'b1;
    wait_a(10, 40);
    n_tests++;
    if (a_qd.size() != 10) begin
      n_fail++; $display("FAIL bp_count got %0d beats, need 10", a_qd.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if (a_qd[i] !== lane_word(i % 2, 8'(i / 2)) || a_ql[i] !== (i == 7)) begin
          n_fail++;
          $display("FAIL bp_beat%0d got %h last=%b, need %h last=%b",
                   i, a_qd[i], a_ql[i], lane_word(i % 2, 8'(i / 2)), (i == 7));
        end
      end
      n_tests++;
      if (a_qc[9] - a_qc[0] != 9) begin
        n_fail++; $display("FAIL bp_no_gaps got span %0d, need 9", a_qc[9] - a_qc[0]);
      end
    end
    // Complete the frame so later tests start at cell 0.
    for (int c = 5; c < 8; c++) a_send(8'(c), tmp);
    a_s_valid = 1'b0;
    wait_a(16, 40);
    n_tests++;
    if (a_qd.size() != 16 || a_ql[15] !== 1'b1 || a_frame_count !== 16'd12) begin
      n_fail++;
      $display("FAIL bp_tail got beats=%0d frame=%0d, need 16 12 with final tlast",
               a_qd.size(), a_frame_count);
    end
  endtask

  task automatic test_tready_toggle();
    int          acc;
    logic        pv, pr, pl;
    logic [63:0] pd;
    clear_a();
    a_tready = 1'b0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    fork
      begin
        for (int c = 0; c < 4; c++) a_send(8'h50 + 8'(c), acc);
        a_s_valid = 1'b0;
      end
      begin
        repeat (40) begin @(posedge clk); #1; a_tready = ~a_tready; end
      end
      begin
        repeat (40) begin
          @(negedge clk);
          if (pv && !pr) begin
            n_tests++;
            if (a_tvalid !== 1'b1 || a_tdata !== pd || a_tlast !== pl) begin
              n_fail++;
              $display("FAIL toggle_stable got v=%b d=%h l=%b, need 1 %h %b",
                       a_tvalid, a_tdata, a_tlast, pd, pl);
            end
          end
          pv = a_tvalid; pr = a_tready; pd = a_tdata; pl = a_tlast;
        end
      end
    join
    a_tready = 1'b1;
    wait_a(8, 20);
    n_tests++;
    if (a_qd.size() != 8) begin
      n_fail++; $display("FAIL toggle_count got %0d beats, need 8", a_qd.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (a_qd[i] !== lane_word(i % 2, 8'h50 + 8'(i / 2)) || a_ql[i] !== (i == 7)) begin
          n_fail++;
          $display("FAIL toggle_beat%0d got %h last=%b, need %h last=%b",
                   i, a_qd[i], a_ql[i], lane_word(i % 2, 8'h50 + 8'(i / 2)), (i == 7));
        end
      end
    end
  endtask

  // Cell 0 moves to the holding register while cell 1 arrives, so cells 1..3 fill
  // the three unreserved slots, 4..6 are dropped and 7 takes the reserved slot.
  task automatic test_drop();
    int         i;
    logic [7:0] exp_tag [5];
    exp_tag[0] = 8'd0; exp_tag[1] = 8'd1; exp_tag[2] = 8'd2; exp_tag[3] = 8'd3; exp_tag[4] = 8'd7;
    b_tready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      b_s_valid = 1'b1;
      b_s_data  = cell_data(8'(c));
      @(posedge clk); #1;
    end
    b_s_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (b_s_ready !== 1'b1 || b_overflow !== 1'b1 || b_drop_count !== 16'd3) begin
      n_fail++;
      $display("FAIL drop_counters got s_ready=%b ovf=%b drops=%0d, need 1 1 3",
               b_s_ready, b_overflow, b_drop_count);
    end
    @(posedge clk); #1;
    b_tready = 1'b1;
    i = 0;
    while (b_qd.size() < 10 && i < 40) begin @(posedge clk); i++; end
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (b_qd.size() != 10) begin
      n_fail++; $display("FAIL drop_count_beats got %0d, need 10", b_qd.size());
    end else begin
      for (int j = 0; j < 10; j++) begin
        n_tests++;
        if (b_qd[j] !== lane_word(j % 2, exp_tag[j / 2]) || b_ql[j] !== (j == 9)) begin
          n_fail++;
          $display("FAIL drop_beat%0d got %h last=%b, need %h last=%b",
                   j, b_qd[j], b_ql[j], lane_word(j % 2, exp_tag[j / 2]), (j == 9));
        end
      end
    end
    n_tests++;
    if (b_frame_count !== 16'd1) begin
      n_fail++; $display("FAIL drop_frame_count got %0d, need 1", b_frame_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc;
    clear_a();
    a_tready = 1'b0;
    a_send(8'h60, acc);
    a_send(8'h61, acc);
    a_s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (a_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre got tvalid=%b, need 1", a_tvalid);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (a_tvalid !== 1'b0 || a_tlast !== 1'b0 || a_s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async got tvalid=%b tlast=%b s_ready=%b, need 0 0 0",
               a_tvalid, a_tlast, a_s_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    clear_a();
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (a_frame_count !== 16'd0 || b_frame_count !== 16'd0 || b_drop_count !== 16'd0 || b_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_counters got a_frame=%0d b_frame=%0d drops=%0d ovf=%b, need 0 0 0 0",
               a_frame_count, b_frame_count, b_drop_count, b_overflow);
    end
    a_tready = 1'b1;
    for (int c = 0; c < 4; c++) a_send(8'h70 + 8'(c), acc);
    a_s_valid = 1'b0;
    wait_a(8, 40);
    n_tests++;
    if (a_qd.size() != 8) begin
      n_fail++; $display("FAIL midrst_count got %0d beats, need 8", a_qd.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (a_qd[i] !== lane_word(i % 2, 8'h70 + 8'(i / 2)) || a_ql[i] !== (i == 7)) begin
          n_fail++;
          $display("FAIL midrst_beat%0d got %h last=%b, need %h last=%b",
                   i, a_qd[i], a_ql[i], lane_word(i % 2, 8'h70 + 8'(i / 2)), (i == 7));
        end
      end
    end
    n_tests++;
    if (a_frame_count !== 16'd1) begin
      n_fail++; $display("FAIL midrst_frame_count got %0d, need 1", a_frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decim();
    test_backpressure();
    test_tready_toggle();
    test_drop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded 200000 time units");
    $fatal(1, "watchdog");
  end
endmodule
